// File: rtl/gaussian_job_sched.sv
// Gaussian AFU job sequencer: streams buffer 0 into the filter kernel, writes kernel results to buffer 1,
// then posts a completion line to the DSM. Define GAUSSIAN_SCHED_PERF_EN to report RUN cycles in the DSM line.
module gaussian_job_sched #(
  parameter int ADDR_W  = 42,
  parameter int MAX_OUT = 64,
  parameter int TAG_W   = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       hc_control,
  input  logic [ADDR_W-1:0] hc_dsm_base,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_size,
  input  logic [ADDR_W-1:0] out_addr,
  input  logic [31:0]       out_size,
  input  logic              c0_alm_full,
  output logic              rd_req_valid,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [TAG_W-1:0]  rd_req_tag,
  input  logic              rd_rsp_valid,
  input  logic [511:0]      rd_rsp_data,
  output logic              kin_valid,
  output logic [511:0]      kin_data,
  input  logic              kout_valid,
  input  logic [511:0]      kout_data,
  output logic              kout_ready,
  input  logic              c1_alm_full,
  output logic              wr_req_valid,
  output logic [ADDR_W-1:0] wr_req_addr,
  output logic [511:0]      wr_req_data,
  input  logic              wr_rsp_valid,
  output logic              busy
);

  localparam int CNT_W = 26;
  localparam int OUT_W = $clog2(MAX_OUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DSM,
    S_WAIT_ACK
  } state_t;

  state_t state, state_next;

  logic              ctrl_start_q;
  logic              start_cmd;
  logic              start_acc;
  logic [ADDR_W-1:0] in_base;
  logic [ADDR_W-1:0] out_base;
  logic [ADDR_W-1:0] dsm_base;
  logic [CNT_W-1:0]  n_in;
  logic [CNT_W-1:0]  n_out;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  ack_cnt;
  logic [OUT_W-1:0]  outst;
  logic              rd_issue;
  logic              rsp_take;
  logic              kout_take;
  logic              dsm_fire;
  logic              run_done;
  logic [31:0]       perf_word;
  logic [511:0]      dsm_line;

  function automatic logic [CNT_W-1:0] line_count(input logic [31:0] size);
    return CNT_W'((size + 32'd63) >> 6);
  endfunction

  // Start is the rising edge of "hc_control == 1", so a held START cannot relaunch a finished job.
  assign start_cmd = (hc_control == 32'd1) && !ctrl_start_q;
  assign start_acc = start_cmd && (state == S_IDLE);
  assign rsp_take  = (state == S_RUN) && rd_rsp_valid && (outst != '0);
  assign run_done  = (rd_cnt == n_in) && (outst == '0) && (wr_cnt == n_out) && (ack_cnt == n_out);
  assign busy      = (state != S_IDLE);
  assign dsm_line  = {448'd0, perf_word, 31'd0, 1'b1};

  // NOTE: every signal written here gets a default first, otherwise paths that skip it infer latches.
  always_comb begin
    state_next   = state;
    rd_issue     = 1'b0;
    kout_ready   = 1'b0;
    kout_take    = 1'b0;
    dsm_fire     = 1'b0;
    rd_req_valid = 1'b0;
    rd_req_addr  = '0;
    rd_req_tag   = '0;
    unique case (state)
      S_IDLE: begin
        if (start_cmd) state_next = S_RUN;
      end
      S_RUN: begin
        rd_issue   = (rd_cnt < n_in) && !c0_alm_full && (outst < OUT_W'(MAX_OUT));
        kout_ready = (wr_cnt < n_out) && !c1_alm_full;
        kout_take  = kout_ready && kout_valid;
        if (rd_issue) begin
          rd_req_valid = 1'b1;
          rd_req_addr  = in_base + ADDR_W'(rd_cnt);
          rd_req_tag   = rd_cnt[TAG_W-1:0];
        end
        if (run_done) state_next = S_DSM;
      end
      S_DSM: begin
        if (!c1_alm_full) begin
          dsm_fire   = 1'b1;
          state_next = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (wr_rsp_valid) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      ctrl_start_q <= 1'b0;
      in_base      <= '0;
      out_base     <= '0;
      dsm_base     <= '0;
      n_in         <= '0;
      n_out        <= '0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      ack_cnt      <= '0;
      outst        <= '0;
    end else begin
      state        <= state_next;
      ctrl_start_q <= (hc_control == 32'd1);
      if (start_acc) begin
        in_base  <= in_addr;
        out_base <= out_addr;
        dsm_base <= hc_dsm_base;
        n_in     <= line_count(in_size);
        n_out    <= line_count(out_size);
        rd_cnt   <= '0;
        wr_cnt   <= '0;
        ack_cnt  <= '0;
        outst    <= '0;
      end else if (state == S_RUN) begin
        if (rd_issue)  rd_cnt <= rd_cnt + CNT_W'(1);
        if (kout_take) wr_cnt <= wr_cnt + CNT_W'(1);
        if (wr_rsp_valid && (ack_cnt < n_out)) ack_cnt <= ack_cnt + CNT_W'(1);
        if (rd_issue && !rsp_take)      outst <= outst + OUT_W'(1);
        else if (!rd_issue && rsp_take) outst <= outst - OUT_W'(1);
      end
    end
  end

  // NOTE: the wide data registers are reset too, because every output must read 0 straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      kin_valid    <= 1'b0;
      kin_data     <= '0;
      wr_req_valid <= 1'b0;
      wr_req_addr  <= '0;
      wr_req_data  <= '0;
    end else begin
      kin_valid    <= (state == S_RUN) && rd_rsp_valid;
      if ((state == S_RUN) && rd_rsp_valid) kin_data <= rd_rsp_data;
      wr_req_valid <= kout_take || dsm_fire;
      if (kout_take) begin
        wr_req_addr <= out_base + ADDR_W'(wr_cnt);
        wr_req_data <= kout_data;
      end else if (dsm_fire) begin
        wr_req_addr <= dsm_base;
        wr_req_data <= dsm_line;
      end
    end
  end

`ifdef GAUSSIAN_SCHED_PERF_EN
  logic [31:0] perf_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles <= '0;
    end else if (start_acc) begin
      perf_cycles <= '0;
    end else if ((state == S_RUN) && (perf_cycles != '1)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end

  assign perf_word = perf_cycles;
`else
  assign perf_word = '0;
`endif

endmodule
